// File: rtl/rf_pkg.sv
// Shared definitions for the register-file access path.
//   XLEN / REG_AW   : datapath and register-address widths
//   PHASE_RD        : phase-0, write presented to the RF / read data returned
//   PHASE_WR        : phase-1, write committed in the RF / reads accepted
//   wr_req_t        : write request payload {rd, data}
package rf_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic PHASE_RD = 1'b0;
   localparam logic PHASE_WR = 1'b1;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wr_req_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-operand forward select: picks the bypassed write data when it targets
// the same non-zero register, otherwise passes the register-file read data.
//   addr      : operand register address
//   rf_val    : register-file read data for addr
//   byp_v     : bypass entry valid
//   byp_rd    : bypass entry destination register
//   byp_data  : bypass entry data
//   operand_c : forwarded operand value (combinational)
module rf_bypass_mux
   import rf_pkg::*;
(
   input  logic [REG_AW-1:0] addr,
   input  logic [XLEN-1:0]   rf_val,
   input  logic              byp_v,
   input  logic [REG_AW-1:0] byp_rd,
   input  logic [XLEN-1:0]   byp_data,
   output logic [XLEN-1:0]   operand_c
);

   logic hit_c;

   // x0 never forwards; the RF already returns 0 for it
   always_comb begin
      hit_c     = 1'b0;
      operand_c = rf_val;
      hit_c     = (addr != '0) && byp_v && (byp_rd == addr);
      if (hit_c) begin
         operand_c = byp_data;
      end
   end

endmodule

// File: rtl/rf_access_ctrl.sv
// Initiator-side controller for the two-phase register file. Accepts one
// operand read and one writeback per 2-cycle period, drives the RF ports with
// phase alignment and forwards the write of the read's own period.
//   clk, rst_n                        : clock, async active-low reset
//   req_valid/req_ready/req_rs1/rs2/tag : read request handshake
//   wb_valid/wb_ready/wb_rd/wb_data   : write request handshake
//   rsp_valid/rsp_rs1_v/rsp_rs2_v/rsp_tag : read response (one-cycle pulse)
//   rf_rs1/rf_rs2/rf_rd/rf_rd_v/rf_we : to register file
//   rf_rs1_v/rf_rs2_v                 : from register file
module rf_access_ctrl
   import rf_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [REG_AW-1:0] req_rs1,
   input  logic [REG_AW-1:0] req_rs2,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rs1_v,
   output logic [XLEN-1:0]   rsp_rs2_v,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [REG_AW-1:0] rf_rs1,
   output logic [REG_AW-1:0] rf_rs2,
   output logic [REG_AW-1:0] rf_rd,
   output logic [XLEN-1:0]   rf_rd_v,
   output logic              rf_we,
   input  logic [XLEN-1:0]   rf_rs1_v,
   input  logic [XLEN-1:0]   rf_rs2_v
);

   logic phase_q, phase_d;

   logic              pend_v_q;
   wr_req_t           pend_q;
   logic              iss_v_q;
   wr_req_t           iss_q;
   logic              we_q;
   logic              byp_v_q;
   wr_req_t           byp_q;
   logic              s1_v_q;
   logic [TAG_W-1:0]  s1_tag_q;
   logic [REG_AW-1:0] rs1_q, rs2_q;
   logic              s2_v_q;
   logic [TAG_W-1:0]  s2_tag_q;
   logic [REG_AW-1:0] s2_rs1_q, s2_rs2_q;

   logic              wr_acc_c;
   logic              rd_acc_c;
   wr_req_t           wb_req_c;
   logic [XLEN-1:0]   op1_c, op2_c;

   // Phase state register, mirrors the RF's own phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PHASE_WR;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Phase next-state and handshake decode
   always_comb begin
      phase_d     = phase_q;
      wb_req_c    = '0;
      wr_acc_c    = 1'b0;
      rd_acc_c    = 1'b0;
      case (phase_q)
         PHASE_RD: phase_d = PHASE_WR;
         default:  phase_d = PHASE_RD;
      endcase
      wb_req_c.rd   = wb_rd;
      wb_req_c.data = wb_data;
      // x0 writes are acknowledged but never stored
      wr_acc_c = wb_valid && !pend_v_q && (wb_rd != '0);
      rd_acc_c = req_valid && (phase_q == PHASE_WR);
   end

   // Datapath: write staging, issue, bypass and read pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v_q <= 1'b0;
         pend_q   <= '0;
         iss_v_q  <= 1'b0;
         iss_q    <= '0;
         we_q     <= 1'b0;
         byp_v_q  <= 1'b0;
         byp_q    <= '0;
         s1_v_q   <= 1'b0;
         s1_tag_q <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         s2_v_q   <= 1'b0;
         s2_tag_q <= '0;
         s2_rs1_q <= '0;
         s2_rs2_q <= '0;
      end else if (phase_q == PHASE_WR) begin
         // End of period: the write issued this period becomes the bypass
         // entry for the reads that were addressed during it.
         byp_v_q  <= iss_v_q;
         byp_q    <= iss_q;
         s2_v_q   <= s1_v_q;
         s2_tag_q <= s1_tag_q;
         s2_rs1_q <= rs1_q;
         s2_rs2_q <= rs2_q;
         // A staged write is older than anything arriving now
         if (pend_v_q) begin
            iss_v_q <= 1'b1;
            iss_q   <= pend_q;
            we_q    <= 1'b1;
         end else if (wr_acc_c) begin
            iss_v_q <= 1'b1;
            iss_q   <= wb_req_c;
            we_q    <= 1'b1;
         end else begin
            iss_v_q <= 1'b0;
            we_q    <= 1'b0;
         end
         pend_v_q <= 1'b0;
         s1_v_q   <= rd_acc_c;
         if (rd_acc_c) begin
            rs1_q    <= req_rs1;
            rs2_q    <= req_rs2;
            s1_tag_q <= req_tag;
         end
      end else begin
         // A phase-1 write enable would be re-sampled by the RF
         we_q   <= 1'b0;
         s2_v_q <= 1'b0;
         if (wr_acc_c) begin
            pend_v_q <= 1'b1;
            pend_q   <= wb_req_c;
         end
      end
   end

   rf_bypass_mux u_byp_rs1 (
      .addr      (s2_rs1_q),
      .rf_val    (rf_rs1_v),
      .byp_v     (byp_v_q),
      .byp_rd    (byp_q.rd),
      .byp_data  (byp_q.data),
      .operand_c (op1_c)
   );

   rf_bypass_mux u_byp_rs2 (
      .addr      (s2_rs2_q),
      .rf_val    (rf_rs2_v),
      .byp_v     (byp_v_q),
      .byp_rd    (byp_q.rd),
      .byp_data  (byp_q.data),
      .operand_c (op2_c)
   );

   assign req_ready = (phase_q == PHASE_WR);
   assign wb_ready  = !pend_v_q;
   assign rf_rs1    = rs1_q;
   assign rf_rs2    = rs2_q;
   assign rf_rd     = iss_q.rd;
   assign rf_rd_v   = iss_q.data;
   assign rf_we     = we_q;

   // Response fields read as zero outside the valid pulse
   assign rsp_valid = s2_v_q;
   assign rsp_rs1_v = s2_v_q ? op1_c : '0;
   assign rsp_rs2_v = s2_v_q ? op2_c : '0;
   assign rsp_tag   = s2_v_q ? s2_tag_q : '0;

endmodule
